// File: rtl/doorlock_pkg.sv
// Shared types and helpers for the passcode entry controller.
package doorlock_pkg;

  // Controller states; the encoding is visible on the display port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_PROG    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_e;

  // One BCD digit.
  typedef logic [3:0] digit_t;

  // Converts a one-hot keypad vector to its BCD digit; callers check one-hotness first.
  function automatic digit_t onehot_to_bcd(input logic [9:0] onehot);
    digit_t d;
    d = '0;
    for (int k = 0; k < 10; k++) begin
      if (onehot[k]) d = digit_t'(k);
    end
    return d;
  endfunction

endpackage

// File: rtl/door_timer.sv
// Loadable down-counter shared by the entry timeout, unlock window and lockout period.
// done_o is high during the last cycle of a loaded interval.
module door_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;

  // Load takes priority; otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/passcode_entry_ctrl.sv
// Keypad passcode controller: collects digits, checks them against a stored code,
// drives the lock, counts failures into an alarm lockout and allows reprogramming.
// Digits are shifted in at nibble 0, so after entering 1,2,3,4 the buffer reads
// 16'h1234 and compares directly against the stored BCD code.
module passcode_entry_ctrl
  import doorlock_pkg::*;
#(
  parameter int          CODE_LEN       = 4,
  parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
  parameter int          MAX_FAIL       = 3,
  parameter int          UNLOCK_CYCLES  = 1000,
  parameter int          LOCKOUT_CYCLES = 5000,
  parameter int          ENTRY_TIMEOUT  = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] digit_pulse,
  input  logic       enter_pulse,
  input  logic       clear_pulse,
  input  logic       prog_pulse,
  output logic       unlock,
  output logic       alarm,
  output logic       fail_pulse,
  output logic       prog_done,
  output logic [3:0] digit_cnt,
  output logic [2:0] state_o
);

  localparam int TMAX_A = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMAX   = (TMAX_A > ENTRY_TIMEOUT) ? TMAX_A : ENTRY_TIMEOUT;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_UNLOCK  = TW'(UNLOCK_CYCLES);
  localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] T_ENTRY   = TW'(ENTRY_TIMEOUT);

  localparam logic [31:0] CODE_MASK  = (CODE_LEN >= 8) ? 32'hFFFF_FFFF
                                                       : ((32'h1 << (4 * CODE_LEN)) - 32'h1);
  localparam logic [3:0]  LEN4       = 4'(CODE_LEN);
  localparam logic [7:0]  FAIL_LIMIT = 8'(MAX_FAIL);

  state_e          state_q, state_d;
  logic [31:0]     buf_q, buf_d;
  logic [31:0]     code_q, code_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      fail_q, fail_d;
  logic            unlock_q, unlock_d;
  logic            alarm_q, alarm_d;
  logic            fail_pulse_q, fail_pulse_d;
  logic            prog_done_q, prog_done_d;

  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_done;

  logic            digit_ok;
  digit_t          digit_val;
  logic            code_match;
  logic [7:0]      fail_inc;

  assign digit_ok   = $onehot(digit_pulse);
  assign digit_val  = onehot_to_bcd(digit_pulse);
  assign code_match = (cnt_q == LEN4) && (buf_q == code_q);
  assign fail_inc   = (fail_q >= FAIL_LIMIT) ? FAIL_LIMIT : fail_q + 8'd1;

  door_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Next-state logic: keypress priority is clear > enter > digit, timeout last.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    fail_d       = fail_q;
    unlock_d     = 1'b0;
    alarm_d      = 1'b0;
    fail_pulse_d = 1'b0;
    prog_done_d  = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = T_ENTRY;
    case (state_q)
      ST_IDLE: begin
        if (digit_ok && !clear_pulse && !enter_pulse) begin
          buf_d    = {28'd0, digit_val};
          cnt_d    = 4'd1;
          tmr_load = 1'b1;
          tmr_val  = T_ENTRY;
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY, ST_PROG: begin
        if (clear_pulse) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (enter_pulse) begin
          if (state_q == ST_ENTRY) begin
            state_d = ST_CHECK;
          end else begin
            if (cnt_q == LEN4) begin
              code_d      = buf_q;
              prog_done_d = 1'b1;
            end
            buf_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else if (digit_ok) begin
          tmr_load = 1'b1;
          tmr_val  = T_ENTRY;
          if (cnt_q < LEN4) begin
            buf_d = {buf_q[27:0], digit_val} & CODE_MASK;
            cnt_d = cnt_q + 4'd1;
          end
        end else if (tmr_done) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (code_match) begin
          fail_d   = '0;
          unlock_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = T_UNLOCK;
          state_d  = ST_OPEN;
        end else begin
          fail_pulse_d = 1'b1;
          fail_d       = fail_inc;
          if (fail_inc >= FAIL_LIMIT) begin
            alarm_d  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = T_LOCKOUT;
            state_d  = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OPEN: begin
        if (prog_pulse) begin
          buf_d    = '0;
          cnt_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = T_ENTRY;
          state_d  = ST_PROG;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end else begin
          unlock_d = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end else begin
          alarm_d = 1'b1;
        end
      end
      default: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, buffers and registered outputs; reset restores the factory code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      code_q       <= DEFAULT_CODE & CODE_MASK;
      cnt_q        <= '0;
      fail_q       <= '0;
      unlock_q     <= 1'b0;
      alarm_q      <= 1'b0;
      fail_pulse_q <= 1'b0;
      prog_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      fail_q       <= fail_d;
      unlock_q     <= unlock_d;
      alarm_q      <= alarm_d;
      fail_pulse_q <= fail_pulse_d;
      prog_done_q  <= prog_done_d;
    end
  end

  assign unlock     = unlock_q;
  assign alarm      = alarm_q;
  assign fail_pulse = fail_pulse_q;
  assign prog_done  = prog_done_q;
  assign digit_cnt  = cnt_q;
  assign state_o    = state_q;

endmodule
